// File: rtl/c_result_drain_pkg.sv
//------------------------------------------------------------------------------
// Module  : c_result_drain_pkg
// Brief   : Shared types and constants for the C result drain path.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package c_result_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2
    } drain_state_t;

    // Matches the read latency of the C result SRAM.
    localparam int C_RD_DELAY = 2;

endpackage

`default_nettype wire

// File: rtl/c_result_drain_fifo.sv
//------------------------------------------------------------------------------
// Module  : drain_fifo
// Brief   : First-word-fall-through skid FIFO for the drained result stream.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module drain_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_rd_valid,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_rd;
    logic w_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_rd    = i_rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = i_wr_en && (!w_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_valid = !w_empty;
    assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/c_result_drain.sv
//------------------------------------------------------------------------------
// Module  : c_result_drain
// Brief   : Drains completed C result tiles from the result buffer into a
//           valid/ready stream, one tile at a time, with overrun detection.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module c_result_drain
    import c_result_drain_pkg::*;
#(
    parameter int D_WIDTH    = 64,
    parameter int ADDR_W     = 2,
    parameter int RD_DELAY   = C_RD_DELAY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               output_trigger_in,
    output logic               res_rd_en_out,
    output logic [ADDR_W-1:0]  res_rd_addr_out,
    input  logic [D_WIDTH-1:0] res_rd_data_in,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_last,
    output logic [15:0]        tile_count_out,
    output logic               overrun_err_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    drain_state_t r_state;
    drain_state_t w_state_nxt;

    logic                r_trig;
    logic [1:0]          r_pend;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_inflight;
    logic [RD_DELAY-1:0] r_pipe_vld;
    logic [RD_DELAY-1:0] r_pipe_lst;
    logic [15:0]         r_tiles;
    logic                r_overrun;

    logic                w_toggle;
    logic                w_inc;
    logic                w_drop;
    logic                w_done;
    logic                w_issue;
    logic                w_room;
    logic                w_addr_last;
    logic                w_wr;
    logic                w_wr_last;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [CNT_W:0]      w_occ;

    // Trigger edge detect and pending-tile bookkeeping.
    assign w_toggle = r_trig ^ output_trigger_in;
    assign w_drop   = w_toggle && (r_pend == 2'd2) && !w_done;
    assign w_inc    = w_toggle && !w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig    <= output_trigger_in;
            r_pend    <= 2'd0;
            r_overrun <= 1'b0;
        end else begin
            r_trig <= output_trigger_in;
            r_pend <= r_pend + {1'b0, w_inc} - {1'b0, w_done};
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Reads only issue while every in-flight word is guaranteed a FIFO slot.
    assign w_occ       = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign w_room      = (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_addr_last = (r_addr == {ADDR_W{1'b1}});

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend != 2'd0) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_issue = w_room;
                if (w_room && w_addr_last) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_inflight == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_inflight <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            case ({w_issue, w_wr})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    generate
        if (RD_DELAY == 1) begin : g_pipe_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe_vld <= '0;
                    r_pipe_lst <= '0;
                end else begin
                    r_pipe_vld <= w_issue;
                    r_pipe_lst <= w_issue && w_addr_last;
                end
            end
        end else begin : g_pipe_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe_vld <= '0;
                    r_pipe_lst <= '0;
                end else begin
                    r_pipe_vld <= {r_pipe_vld[RD_DELAY-2:0], w_issue};
                    r_pipe_lst <= {r_pipe_lst[RD_DELAY-2:0], w_issue && w_addr_last};
                end
            end
        end
    endgenerate

    assign w_wr      = r_pipe_vld[RD_DELAY-1];
    assign w_wr_last = r_pipe_lst[RD_DELAY-1];

    drain_fifo #(
        .WIDTH (D_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr),
        .i_wr_data  ({w_wr_last, res_rd_data_in}),
        .i_rd_en    (m_ready),
        .o_rd_valid (m_valid),
        .o_rd_data  ({m_last, m_data}),
        .o_count    (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tiles <= 16'd0;
        end else if (m_valid && m_ready && m_last) begin
            r_tiles <= r_tiles + 16'd1;
        end
    end

    assign res_rd_en_out   = w_issue;
    assign res_rd_addr_out = r_addr;
    assign tile_count_out  = r_tiles;
    assign overrun_err_out = r_overrun;

endmodule

`default_nettype wire

// File: doc/c_result_drain.md
C_RESULT_DRAIN -- requirements
Module: c_result_drain

Interface
REQ-001 Parameter D_WIDTH, default 64, width of one C result word.
REQ-002 Parameter ADDR_W, default 2, result buffer address width; tile length = 2^ADDR_W words.
REQ-003 Parameter RD_DELAY, default 2, cycles from result read enable to valid read data.
REQ-004 Parameter FIFO_DEPTH, default 4, output skid FIFO depth; must be >= RD_DELAY+1.
REQ-005 clk  input  1  sole clock; also drives the result buffer read clock at top level.
REQ-006 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 output_trigger_in  input  1  store-buffer index from the C controller; each toggle means one completed tile is readable.
REQ-008 res_rd_en_out  output  1  read enable to the C controller result port.
REQ-009 res_rd_addr_out  output  ADDR_W  read address to the C controller result port.
REQ-010 res_rd_data_in  input  D_WIDTH  read data, valid RD_DELAY cycles after the read-enable cycle.
REQ-011 m_valid  output  1  output stream word valid.
REQ-012 m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high.
REQ-013 m_data  output  D_WIDTH  output stream word.
REQ-014 m_last  output  1  high on the final word (address 2^ADDR_W-1) of a tile.
REQ-015 tile_count_out  output  16  count of tiles fully transferred; wraps at 2^16.
REQ-016 overrun_err_out  output  1  sticky flag: tile completion lost.

Function
REQ-017 Trigger detect: register output_trigger_in; a toggle = registered value differs from input, sampled on each clk edge.
REQ-018 Pending counter 0..2: +1 per detected toggle, -1 when a drain completes; simultaneous +1/-1 leaves it unchanged.
REQ-019 Toggle detected while pending = 2 and no drain completion in the same cycle: the toggle is dropped and overrun_err_out is set to 1.
REQ-020 FSM states IDLE, READ, WAIT; IDLE->READ when pending > 0; READ->WAIT in the cycle the address 2^ADDR_W-1 is issued; WAIT->IDLE when the in-flight count is 0 and the last word is written to the FIFO; the drain completes on the WAIT->IDLE transition.
REQ-021 READ: res_rd_en_out = 1 only when fifo_count + inflight < FIFO_DEPTH; address starts at 0 and increments by 1 per issued read.
REQ-022 The in-flight counter tracks issued reads not yet returned; the read data is written to the FIFO exactly RD_DELAY cycles after the issue cycle, tagged with last = (issued address == 2^ADDR_W-1).
REQ-023 res_rd_en_out = 0 in IDLE and WAIT; res_rd_addr_out holds its value when not issuing.
REQ-024 FIFO: first-word-fall-through; a word written in cycle t is visible on m_valid/m_data in cycle t+1; a simultaneous write and read on a full FIFO is legal.
REQ-025 m_data and m_last are stable while m_valid=1 and m_ready=0.
REQ-026 Throughput: with m_ready held high, one word per cycle is sustained; first m_valid is RD_DELAY+1 cycles after the first res_rd_en_out.
REQ-027 tile_count_out increments in the cycle a transfer with m_last=1 occurs.
REQ-028 Reads of the next tile start no earlier than the cycle after WAIT->IDLE; words of consecutive tiles are never interleaved.

Reset
REQ-029 rst_n low asynchronously clears: FSM to IDLE, pending, in-flight, address, FIFO pointers/count, tile_count_out, overrun_err_out, the delay pipeline valid bits, and samples output_trigger_in into the trigger register.
REQ-030 During reset: res_rd_en_out=0, res_rd_addr_out=0, m_valid=0, m_last=0, m_data=0.
REQ-031 Reset asserted mid-drain discards all in-flight and buffered words; no partial tile is emitted after reset release.

Structure
REQ-032 Shared package holds the FSM state enum (IDLE/READ/WAIT) and the default RD_DELAY constant, which matches the result SRAM read delay.
REQ-033 One sub-module, drain_fifo (parameterised D_WIDTH+1 wide, FIFO_DEPTH deep, FWFT), holds the output buffering; the pending counter, FSM and read pipeline stay in c_result_drain.

Verification
REQ-034 Single toggle, m_ready=1, buffer words 0xA0..0xA3 -> res_rd_en_out high for 4 consecutive cycles at addresses 0..3; m_data A0..A3 in order; m_last on A3 only; tile_count_out=1.
REQ-035 Backpressure: m_ready=0 for 10 cycles after the toggle -> at most FIFO_DEPTH reads are issued; no words are lost or duplicated after release; the order is unchanged.
REQ-036 Three toggles back-to-back while draining is stalled -> two tiles are emitted, overrun_err_out=1, tile_count_out=2.
REQ-037 Toggle coincident with drain completion at pending=2 -> no overrun; pending remains 2.
REQ-038 rst_n pulsed low while word 2 is in flight -> outputs are at their reset values immediately; after release, with no toggle, m_valid stays 0.
REQ-039 Random m_ready at 50% over 100 tiles -> scoreboard matches all words; tile_count_out=100; overrun_err_out=0.
